inst_dispatch: RTL
==================

INST_DISPATCH -- requirements
Module: inst_dispatch

Interface
REQ-001 SHALL have parameter INST_LEN, default 256, meaning instruction word width.
REQ-002 SHALL have parameter N_CH, default 4, range 1..14, meaning number of DMA channels.
REQ-003 SHALL have parameter CNT_W, default 32, meaning performance counter width.
REQ-004 SHALL have port clk, input, 1 bit, meaning clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, meaning reset: synchronous, active-low, clock clk.
REQ-006 SHALL have port instruct, input, INST_LEN bits, meaning FWFT FIFO head word.
REQ-007 SHALL have port inst_empty, input, 1 bit, meaning FIFO empty.
REQ-008 SHALL have port inst_req, output, 1 bit, meaning one-cycle pop strobe.
REQ-009 SHALL have port cmp_idle, input, 1 bit, meaning compute engine idle.
REQ-010 SHALL have port cmp_conf, output, 1 bit, meaning compute issue pulse.
REQ-011 SHALL have port ch_idle, input, N_CH bits, meaning per-channel idle.
REQ-012 SHALL have port ch_conf, output, N_CH bits, meaning per-channel issue pulse, one-hot or zero.
REQ-013 SHALL have port payload, output, INST_LEN-4-(N_CH+1) bits, meaning registered payload, valid with any conf.
REQ-014 SHALL have port err, output, 1 bit, meaning sticky illegal-type flag.
REQ-015 SHALL have port done, output, 1 bit, meaning halt reached, level.
REQ-016 SHALL have port issue_cnt, output, CNT_W bits, meaning issued instructions.
REQ-017 SHALL have port stall_cnt, output, CNT_W bits, meaning cycles spent blocked in CHECK.

Function
REQ-018 SHALL decode instruct as: type [3:0]; dep mask [4+N_CH:4]; payload = remaining upper bits.
REQ-019 SHALL treat dep bit 0 as compute and dep bit k (1..N_CH) as channel k-1.
REQ-020 SHALL decode type 0 as compute, 1..N_CH as channel type-1, 15 as HALT, and all other values as illegal.
REQ-021 SHALL use three states: FETCH, CHECK, HALTED.
REQ-022 SHALL, in FETCH with inst_empty=0, latch instruct into an internal register and go to CHECK; with inst_empty=1, SHALL stay in FETCH.
REQ-023 SHALL hold a pending bit per resource, set on that resource's conf and cleared on the first cycle its idle input is 0.
REQ-024 SHALL consider a resource free when its idle=1 and its pending=0.
REQ-025 SHALL, in CHECK, issue when the target resource and all dep-masked resources are free: assert the target conf plus inst_req for one cycle, drive payload, increment issue_cnt, and return to FETCH.
REQ-026 SHALL, in CHECK when blocked, hold all outputs, increment stall_cnt, and remain in CHECK.
REQ-027 SHALL, for an illegal type in CHECK, pulse inst_req, set err, issue nothing, and return to FETCH.
REQ-028 SHALL, for HALT in CHECK, wait until all N_CH+1 resources are free, then pulse inst_req and enter HALTED.
REQ-029 SHALL, in HALTED, hold done=1, fetch nothing, and leave HALTED only on reset.
REQ-030 SHALL issue at most one instruction per two cycles, in strict FIFO order.
REQ-031 SHALL hold payload until the next issue.
REQ-032 SHALL saturate both counters at all-ones, with no wrap.
REQ-033 SHALL let a pending bit set in a cycle take precedence over its clear in the same cycle.

Reset
REQ-034 SHALL, while rst_n=0 at a clock edge, enter FETCH and clear all outputs, pending bits, counters, err and done.
REQ-035 SHALL discard the latched instruction and pop nothing on a reset taken in CHECK.

Verification
REQ-036 SHALL check: compute instruction type=0, dep=0, all idle -> cmp_conf and inst_req high in cycle 2 after inst_empty falls, issue_cnt=1.
REQ-037 SHALL check: channel-2 load type=3 with dep bit0 set, cmp_idle=0 for 5 cycles -> stall_cnt=5, ch_conf=4'b0100 on the cycle cmp_idle rises.
REQ-038 SHALL check: back-to-back type=1 instructions with ch_idle[0] dropping 3 cycles after conf -> second instruction blocked by pending until ch_idle[0] returns to 1.
REQ-039 SHALL check: type=9 with N_CH=4 -> err=1, inst_req pulse, no conf, next instruction issues normally.
REQ-040 SHALL check: HALT while ch_idle[1]=0 -> done rises only after ch_idle[1]=1 and FIFO is not popped again.
REQ-041 SHALL check: rst_n low in CHECK while blocked -> all outputs 0, the same head word is re-fetched after release.

Source files
------------

// File: rtl/inst_dispatch.sv
// inst_dispatch: pops instructions from a FWFT FIFO and issues them to the compute engine or DMA channels once their dependencies are free.
module inst_dispatch #(
    parameter int INST_LEN = 256,
    parameter int N_CH     = 4,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INST_LEN-1:0]          instruct,
    input  logic                         inst_empty,
    output logic                         inst_req,
    input  logic                         cmp_idle,
    output logic                         cmp_conf,
    input  logic [N_CH-1:0]              ch_idle,
    output logic [N_CH-1:0]              ch_conf,
    output logic [INST_LEN-4-(N_CH+1)-1:0] payload,
    output logic                         err,
    output logic                         done,
    output logic [CNT_W-1:0]             issue_cnt,
    output logic [CNT_W-1:0]             stall_cnt
);
    localparam int PW = INST_LEN - 5 - N_CH;
    localparam logic [N_CH:0] ONE = 1;

    typedef enum logic [1:0] {FETCH, CHECK, HALTED} state_t;
    state_t state, state_nx;

    logic [INST_LEN-1:0] inst;
    logic [N_CH:0]       pend, idle, free, dep, tgt, set;
    logic [3:0]          typ;
    logic                legal, halt, ok, pop, issue, stall;

    // Resource vector: bit 0 is compute, bit k is channel k-1.
    assign idle  = {ch_idle, cmp_idle};
    assign free  = idle & ~pend;
    assign typ   = inst[3:0];
    assign dep   = inst[4+N_CH:4];
    assign halt  = typ == 4'hf;
    assign legal = typ <= 4'(N_CH);
    assign tgt   = legal ? ONE << typ : '0;
    assign ok    = ((tgt | dep) & ~free) == '0;
    assign set   = issue ? tgt : '0;
    assign stall = state == CHECK && !pop;
    assign done  = state == HALTED;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        issue    = 1'b0;
        case (state)
            FETCH: if (!inst_empty && !inst_req) state_nx = CHECK;
            CHECK: begin
                pop   = halt ? &free : !legal || ok;
                issue = legal && ok;
                if (pop) state_nx = halt ? HALTED : FETCH;
            end
            default: state_nx = HALTED;
        endcase
    end

    // While inst_req is high the FIFO head is stale, so FETCH waits a cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            inst_req  <= 1'b0;
            cmp_conf  <= 1'b0;
            ch_conf   <= '0;
            payload   <= '0;
            err       <= 1'b0;
            pend      <= '0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state               <= state_nx;
            inst_req            <= pop;
            {ch_conf, cmp_conf} <= set;
            pend                <= set | (pend & idle);
            err                 <= err | (state == CHECK && !legal && !halt);
            if (issue) payload <= inst[INST_LEN-1 -: PW];
            if (issue && !(&issue_cnt)) issue_cnt <= issue_cnt + 1'b1;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FETCH && state_nx == CHECK) inst <= instruct;
    end
endmodule
